gpio_od_pad_bank: RTL

Parametrised pad-control bank that sits between the processor system's GPIO/TWI signals and the top-level IOBUF primitives. It supports any number of channels, and each pin is independently configurable as input, push-pull output or open-drain output. Inputs are synchronised and optionally glitch-filtered, then edge-detected into sticky interrupt flags. Pins in output mode are checked for bus contention. One instance serves both the 8-bit GPIO bank and the TWI SDA/SCL pair (WIDTH=2, open-drain).

---
 rtl/gpio_od_pad_bank_if.sv | 36 +++
 rtl/gpio_od_pad_bank.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/gpio_od_pad_bank_if.sv
// Per-pin configuration, pad and status bundle for gpio_od_pad_bank.
// The bank itself connects through the slave modport; a controller or bench uses master.
interface gpio_od_pad_bank_if #(
    parameter int WIDTH = 8
) ();
    logic [WIDTH-1:0] i_out_data;
    logic [WIDTH-1:0] i_dir;
    logic [WIDTH-1:0] i_od_mode;
    logic [WIDTH-1:0] i_pad;
    logic [WIDTH-1:0] o_pad;
    logic [WIDTH-1:0] t_pad;
    logic [WIDTH-1:0] o_in_data;
    logic [WIDTH-1:0] o_rise;
    logic [WIDTH-1:0] o_fall;
    logic [WIDTH-1:0] i_irq_rise_en;
    logic [WIDTH-1:0] i_irq_fall_en;
    logic [WIDTH-1:0] i_irq_clr;
    logic [WIDTH-1:0] o_irq_pending;
    logic             o_irq;
    logic [WIDTH-1:0] i_cont_clr;
    logic [WIDTH-1:0] o_contention;

    modport master (
        output i_out_data, i_dir, i_od_mode, i_pad,
        output i_irq_rise_en, i_irq_fall_en, i_irq_clr, i_cont_clr,
        input  o_pad, t_pad, o_in_data, o_rise, o_fall,
        input  o_irq_pending, o_irq, o_contention
    );

    modport slave (
        input  i_out_data, i_dir, i_od_mode, i_pad,
        input  i_irq_rise_en, i_irq_fall_en, i_irq_clr, i_cont_clr,
        output o_pad, t_pad, o_in_data, o_rise, o_fall,
        output o_irq_pending, o_irq, o_contention
    );
endinterface

// File: rtl/gpio_od_pad_bank.sv
// Pad-control bank: push-pull/open-drain drive, synchronised input path, edge interrupts and contention flags.
// Define GPIO_GLITCH_FILTER_EN to insert the per-pin glitch filter between synchroniser and o_in_data.
module gpio_od_pad_bank #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4
) (
    input logic          i_system_clk,
    input logic          i_system_rst,
    gpio_od_pad_bank_if.slave bus
);

    if (WIDTH < 1 || WIDTH > 32) begin : gWidthCheck
        $error("gpio_od_pad_bank: WIDTH must be 1..32");
    end
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : gSyncCheck
        $error("gpio_od_pad_bank: SYNC_STAGES must be 2..4");
    end
    if (FILTER_LEN < 1 || FILTER_LEN > 255) begin : gFilterCheck
        $error("gpio_od_pad_bank: FILTER_LEN must be 1..255");
    end

`ifdef GPIO_GLITCH_FILTER_EN
    localparam int ChainLen  = SYNC_STAGES;
    localparam int BlankLoad = SYNC_STAGES + FILTER_LEN + 2;
    localparam int CntW      = $clog2(FILTER_LEN + 1);
`else
    // Without the filter the o_in_data register is itself the last synchroniser stage.
    localparam int ChainLen  = SYNC_STAGES - 1;
    localparam int BlankLoad = SYNC_STAGES + 2;
`endif
    localparam int BlankW = $clog2(BlankLoad + 1);

    logic [WIDTH-1:0]  oPad_q, oPad_d;
    logic [WIDTH-1:0]  tPad_q, tPad_d;
    logic [WIDTH-1:0]  sync_q [ChainLen];
    logic [WIDTH-1:0]  syncTail;
    logic [WIDTH-1:0]  inData_q, inData_d;
    logic [WIDTH-1:0]  inPrev_q;
    logic [WIDTH-1:0]  rise, fall;
    logic [WIDTH-1:0]  pend_q, pend_d;
    logic [WIDTH-1:0]  cont_q, cont_d;
    logic [WIDTH-1:0]  contSet;
    logic [BlankW-1:0] blank_q, blank_d;
`ifdef GPIO_GLITCH_FILTER_EN
    logic [CntW-1:0]   cnt_q [WIDTH];
    logic [CntW-1:0]   cnt_d [WIDTH];
`endif

    assign syncTail = sync_q[ChainLen-1];

    // Open-drain pins never drive high: a 1 releases the pin by tristating it.
    always_comb begin
        tPad_d = ~bus.i_dir | (bus.i_od_mode & bus.i_out_data);
        oPad_d = bus.i_dir & ~bus.i_od_mode & bus.i_out_data;
    end

`ifdef GPIO_GLITCH_FILTER_EN
    // o_in_data only follows the synchroniser after FILTER_LEN consecutive disagreeing cycles.
    always_comb begin
        inData_d = inData_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (syncTail[i] != inData_q[i]) begin
                if (cnt_q[i] == CntW'(FILTER_LEN - 1)) begin
                    inData_d[i] = syncTail[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end
`else
    always_comb begin
        inData_d = syncTail;
    end
`endif

    assign rise = inData_q & ~inPrev_q;
    assign fall = ~inData_q & inPrev_q;

    // A driven pin whose readback disagrees with its drive is contention; released pins are never flagged.
    always_comb begin
        contSet = '0;
        if (blank_q == '0) begin
            contSet = ~tPad_q & (inData_q ^ oPad_q);
        end
        cont_d = (cont_q & ~bus.i_cont_clr) | contSet;
        pend_d = (pend_q & ~bus.i_irq_clr) |
                 (rise & bus.i_irq_rise_en) | (fall & bus.i_irq_fall_en);
    end

    // Any drive change restarts blanking so the readback has time to settle before checking.
    always_comb begin
        if (oPad_d != oPad_q || tPad_d != tPad_q) begin
            blank_d = BlankW'(BlankLoad);
        end else if (blank_q != '0) begin
            blank_d = blank_q - 1'b1;
        end else begin
            blank_d = blank_q;
        end
    end

    always_ff @(posedge i_system_clk) begin
        if (i_system_rst) begin
            oPad_q   <= '0;
            tPad_q   <= '1;
            for (int st = 0; st < ChainLen; st++) begin
                sync_q[st] <= '0;
            end
            inData_q <= '0;
            inPrev_q <= '0;
            pend_q   <= '0;
            cont_q   <= '0;
            blank_q  <= BlankW'(BlankLoad);
`ifdef GPIO_GLITCH_FILTER_EN
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
`endif
        end else begin
            oPad_q    <= oPad_d;
            tPad_q    <= tPad_d;
            sync_q[0] <= bus.i_pad;
            for (int st = 1; st < ChainLen; st++) begin
                sync_q[st] <= sync_q[st-1];
            end
            inData_q <= inData_d;
            inPrev_q <= inData_q;
            pend_q   <= pend_d;
            cont_q   <= cont_d;
            blank_q  <= blank_d;
`ifdef GPIO_GLITCH_FILTER_EN
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
`endif
        end
    end

    assign bus.o_pad         = oPad_q;
    assign bus.t_pad         = tPad_q;
    assign bus.o_in_data     = inData_q;
    assign bus.o_rise        = rise;
    assign bus.o_fall        = fall;
    assign bus.o_irq_pending = pend_q;
    assign bus.o_irq         = |pend_q;
    assign bus.o_contention  = cont_q;

endmodule
